// File: rtl/pipe_scheduler.sv
// Frame sequencer for the fractal Pipe: walks the pixel raster, issues coordinates under
// full-flag and credit control, and turns drained iteration counts into framebuffer writes.
module pipe_scheduler #(
    parameter int BIT_WIDTH       = 32,
    parameter int MAX_X           = 64,
    parameter int MAX_Y           = 48,
    parameter int FLOAT_PRECISION = 26,
    parameter int DEPTH           = 16,
    parameter int ADDR_W          = $clog2(MAX_X * MAX_Y)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] x_origin,
    input  logic [BIT_WIDTH-1:0] y_origin,
    input  logic [BIT_WIDTH-1:0] x_step,
    input  logic [BIT_WIDTH-1:0] y_step,
    output logic                 busy,
    output logic                 done,
    output logic                 w_cntrl_real,
    output logic                 w_cntrl_imag,
    output logic [BIT_WIDTH-1:0] data_in_real,
    output logic [BIT_WIDTH-1:0] data_in_imag,
    input  logic                 full_real,
    input  logic                 full_imag,
    output logic                 r_cntrl,
    input  logic [BIT_WIDTH-1:0] data_out,
    input  logic                 empty,
    output logic                 pix_we,
    output logic [ADDR_W-1:0]    pix_addr,
    output logic [BIT_WIDTH-1:0] pix_data
);

    localparam int NPIX  = MAX_X * MAX_Y;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int OUT_W = $clog2(DEPTH + 1);
    localparam int XI_W  = (MAX_X > 1) ? $clog2(MAX_X) : 1;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] ALL_PIX  = CNT_W'(NPIX);
    localparam logic [XI_W-1:0]  X_LAST   = XI_W'(MAX_X - 1);
    localparam logic [OUT_W-1:0] CREDITS  = OUT_W'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // The fraction width only matters to whoever prepares origin/step.
    if (FLOAT_PRECISION >= BIT_WIDTH) begin : g_fmt_check
        $error("FLOAT_PRECISION must be smaller than BIT_WIDTH");
    end

    logic [1:0]           state_q, state_d;
    logic [BIT_WIDTH-1:0] x_org_q, x_org_d, x_stp_q, x_stp_d, y_stp_q, y_stp_d;
    logic [BIT_WIDTH-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [XI_W-1:0]      x_idx_q, x_idx_d;
    logic [CNT_W-1:0]     iss_cnt_q, iss_cnt_d, res_cnt_q, res_cnt_d;
    logic [OUT_W-1:0]     outst_q, outst_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 w_cntrl_q, w_cntrl_d, r_cntrl_q, r_cntrl_d, pix_we_q, pix_we_d;
    logic [BIT_WIDTH-1:0] data_re_q, data_re_d, data_im_q, data_im_d, pix_data_q, pix_data_d;
    logic [ADDR_W-1:0]    pix_addr_q, pix_addr_d;
    logic                 do_issue, do_read;

    assign do_issue = (state_q == RUN) && !full_real && !full_imag && (outst_q < CREDITS);
    // r_cntrl_q high means a read is in flight; its data is captured this edge.
    assign do_read  = ((state_q == RUN) || (state_q == DRAIN)) && !empty &&
                      (outst_q != '0) && !r_cntrl_q;

    always_comb begin
        state_d    = state_q;
        x_org_d    = x_org_q;
        x_stp_d    = x_stp_q;
        y_stp_d    = y_stp_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        x_idx_d    = x_idx_q;
        iss_cnt_d  = iss_cnt_q;
        res_cnt_d  = res_cnt_q;
        outst_d    = outst_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        w_cntrl_d  = 1'b0;
        r_cntrl_d  = do_read;
        pix_we_d   = 1'b0;
        data_re_d  = data_re_q;
        data_im_d  = data_im_q;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_org_d   = x_origin;
                    x_stp_d   = x_step;
                    y_stp_d   = y_step;
                    cur_x_d   = x_origin;
                    cur_y_d   = y_origin;
                    x_idx_d   = '0;
                    iss_cnt_d = '0;
                    res_cnt_d = '0;
                    outst_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (do_issue) begin
                    w_cntrl_d = 1'b1;
                    data_re_d = cur_x_q;
                    data_im_d = cur_y_q;
                    if (x_idx_q == X_LAST) begin
                        x_idx_d = '0;
                        cur_x_d = x_org_q;
                        cur_y_d = cur_y_q + y_stp_q;
                    end else begin
                        x_idx_d = x_idx_q + XI_W'(1);
                        cur_x_d = cur_x_q + x_stp_q;
                    end
                    iss_cnt_d = iss_cnt_q + CNT_W'(1);
                    if (iss_cnt_q == LAST_PIX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (res_cnt_q == ALL_PIX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (r_cntrl_q) begin
            pix_we_d   = 1'b1;
            pix_data_d = data_out;
            pix_addr_d = res_cnt_q[ADDR_W-1:0];
            res_cnt_d  = res_cnt_q + CNT_W'(1);
        end

        case ({do_issue, r_cntrl_q})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            x_org_q    <= '0;
            x_stp_q    <= '0;
            y_stp_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            x_idx_q    <= '0;
            iss_cnt_q  <= '0;
            res_cnt_q  <= '0;
            outst_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            w_cntrl_q  <= 1'b0;
            r_cntrl_q  <= 1'b0;
            pix_we_q   <= 1'b0;
            data_re_q  <= '0;
            data_im_q  <= '0;
            pix_addr_q <= '0;
            pix_data_q <= '0;
        end else begin
            state_q    <= state_d;
            x_org_q    <= x_org_d;
            x_stp_q    <= x_stp_d;
            y_stp_q    <= y_stp_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            x_idx_q    <= x_idx_d;
            iss_cnt_q  <= iss_cnt_d;
            res_cnt_q  <= res_cnt_d;
            outst_q    <= outst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            w_cntrl_q  <= w_cntrl_d;
            r_cntrl_q  <= r_cntrl_d;
            pix_we_q   <= pix_we_d;
            data_re_q  <= data_re_d;
            data_im_q  <= data_im_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign w_cntrl_real = w_cntrl_q;
    assign w_cntrl_imag = w_cntrl_q;
    assign data_in_real = data_re_q;
    assign data_in_imag = data_im_q;
    assign r_cntrl      = r_cntrl_q;
    assign pix_we       = pix_we_q;
    assign pix_addr     = pix_addr_q;
    assign pix_data     = pix_data_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: a 4x2 instance driven by a FIFO-ordered Pipe model with a
// scoreboard, plus a default-size instance with a Pipe that never answers.
`timescale 1ns/1ps
module tb_pipe_scheduler;

    localparam int NP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    // Small-frame instance.
    logic        s_start = 1'b0;
    logic [31:0] s_xo = '0, s_yo = '0, s_xs = '0, s_ys = '0;
    logic        s_busy, s_done, s_wr, s_wi, s_rd, s_pix_we;
    logic [31:0] s_dr, s_di, s_pix_data;
    logic [2:0]  s_pix_addr;
    logic        s_full_r = 1'b0, s_full_i = 1'b0;
    logic [31:0] s_data_out = '0;
    logic        s_empty = 1'b1;

    pipe_scheduler #(.MAX_X(4), .MAX_Y(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start),
        .x_origin(s_xo), .y_origin(s_yo), .x_step(s_xs), .y_step(s_ys),
        .busy(s_busy), .done(s_done),
        .w_cntrl_real(s_wr), .w_cntrl_imag(s_wi),
        .data_in_real(s_dr), .data_in_imag(s_di),
        .full_real(s_full_r), .full_imag(s_full_i),
        .r_cntrl(s_rd), .data_out(s_data_out), .empty(s_empty),
        .pix_we(s_pix_we), .pix_addr(s_pix_addr), .pix_data(s_pix_data)
    );

    // Full-size instance whose Pipe never returns a result.
    logic        b_start = 1'b0;
    logic        b_busy, b_done, b_wr, b_wi, b_rd, b_pix_we;
    logic [31:0] b_dr, b_di, b_pix_data;
    logic [11:0] b_pix_addr;
    logic        b_full = 1'b0;
    logic        b_empty = 1'b1;
    logic [31:0] b_data_out = '0;

    pipe_scheduler u_big (
        .clk(clk), .rst(rst), .start(b_start),
        .x_origin(s_xo), .y_origin(s_yo), .x_step(s_xs), .y_step(s_ys),
        .busy(b_busy), .done(b_done),
        .w_cntrl_real(b_wr), .w_cntrl_imag(b_wi),
        .data_in_real(b_dr), .data_in_imag(b_di),
        .full_real(b_full), .full_imag(b_full),
        .r_cntrl(b_rd), .data_out(b_data_out), .empty(b_empty),
        .pix_we(b_pix_we), .pix_addr(b_pix_addr), .pix_data(b_pix_data)
    );

    typedef struct {
        logic [31:0] xo, yo, xs, ys;
        int          lat;
        bit          rand_e, hold, mid_start;
        logic [31:0] first_re, first_im, last_re, last_im;
    } vec_t;
    vec_t vecs[4];

    typedef struct {
        logic [31:0] val;
        int          rdy;
    } pent_t;

    pent_t       pq[$];
    logic [63:0] exp_co[$];
    logic [31:0] exp_px[$];

    int   total = 0, bad = 0;
    int   cyc = 0;
    int   lat = 1;
    bit   rand_e = 1'b0;
    int   n_iss = 0, pix_cnt = 0, done_cnt = 0;
    int   first_iss_cyc = 0, last_iss_cyc = 0, last_pix_cyc = 0, done_cyc = 0;
    logic [31:0] first_re = '0, first_im = '0, last_re = '0, last_im = '0;
    logic empty_at_edge = 1'b1, prev_rd = 1'b0;
    int   b_iss = 0;
    bit   b_rd_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pipe_fn(input logic [31:0] re, input logic [31:0] im);
        return (re ^ {im[15:0], im[31:16]}) + 32'd7;
    endfunction

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        empty_at_edge <= s_empty;
    end

    // Pipe model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin : mon
        logic [31:0] v;
        logic [63:0] e;
        bit          rdy;
        if (s_rd) begin
            chk("rd_when_empty", {63'd0, empty_at_edge}, 64'd0);
            chk("rd_back_to_back", {63'd0, prev_rd}, 64'd0);
            if (pq.size() > 0) begin
                s_data_out <= pq[0].val;
                void'(pq.pop_front());
            end
        end
        prev_rd <= s_rd;
        if (s_wr || s_wi) begin
            chk("wr_pair", {63'd0, s_wi}, {63'd0, s_wr});
            if (n_iss == 0) begin
                first_re      = s_dr;
                first_im      = s_di;
                first_iss_cyc = cyc;
            end
            last_re      = s_dr;
            last_im      = s_di;
            last_iss_cyc = cyc;
            n_iss++;
            if (exp_co.size() == 0) begin
                chk("issue_overrun", n_iss, NP);
            end else begin
                e = exp_co.pop_front();
                chk("issue_coord", {s_dr, s_di}, e);
            end
            v = pipe_fn(s_dr, s_di);
            pq.push_back('{val: v, rdy: cyc + lat});
            exp_px.push_back(v);
        end
        if (s_pix_we) begin
            chk("pix_addr", {61'd0, s_pix_addr}, pix_cnt);
            if (exp_px.size() == 0) begin
                chk("pix_without_issue", exp_px.size(), 1);
            end else begin
                v = exp_px.pop_front();
                chk("pix_data", s_pix_data, v);
            end
            pix_cnt++;
            last_pix_cyc = cyc;
        end
        if (s_done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_with_done", {63'd0, s_busy}, 64'd0);
        end
        rdy = (pq.size() > 0) && (pq[0].rdy <= cyc);
        if (rand_e && $urandom_range(0, 1) == 0) rdy = 1'b0;
        s_empty <= !rdy;
        if (b_wr) b_iss++;
        if (b_rd) b_rd_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame(input int idx);
        vec_t v;
        v        = vecs[idx];
        lat      = v.lat;
        rand_e   = v.rand_e;
        n_iss    = 0;
        pix_cnt  = 0;
        done_cnt = 0;
        exp_co.delete();
        exp_px.delete();
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 4; x++) begin
                exp_co.push_back({v.xo + 32'(x) * v.xs, v.yo + 32'(y) * v.ys});
            end
        end
        tick();
        s_xo    = v.xo;
        s_yo    = v.yo;
        s_xs    = v.xs;
        s_ys    = v.ys;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("busy_after_start", {63'd0, s_busy}, 64'd1);
    endtask

    task automatic wait_issues(input int n);
        for (int c = 0; c < 500 && n_iss < n; c++) tick();
        chk("wait_issues", {63'd0, n_iss >= n}, 64'd1);
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        int   hold_start;
        v = vecs[idx];
        start_frame(idx);
        if (v.hold) begin
            wait_issues(3);
            s_full_r = 1'b1;
            tick();
            hold_start = n_iss;
            repeat (20) tick();
            chk("hold_no_issue", n_iss, hold_start);
            s_full_r = 1'b0;
        end
        if (v.mid_start) begin
            wait_issues(4);
            s_xo    = 32'hDEAD_BEEF;
            s_yo    = 32'h0BAD_F00D;
            s_start = 1'b1;
            tick();
            s_start = 1'b0;
        end
        for (int c = 0; c < 4000 && done_cnt == 0; c++) tick();
        repeat (3) tick();
        chk("issues", n_iss, NP);
        chk("pixels", pix_cnt, NP);
        chk("done_pulses", done_cnt, 1);
        chk("done_after_last_pix", done_cyc, last_pix_cyc + 1);
        chk("busy_idle", {63'd0, s_busy}, 64'd0);
        chk("first_issue", {first_re, first_im}, {v.first_re, v.first_im});
        chk("last_issue", {last_re, last_im}, {v.last_re, v.last_im});
        if (!v.hold) chk("issue_rate", last_iss_cyc - first_iss_cyc, NP - 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {58'd0, s_busy, s_done, s_wr, s_wi, s_rd, s_pix_we}, 64'd0);
        chk({tag, "_data_in"}, {s_dr, s_di}, 64'd0);
        chk({tag, "_pix"}, {29'd0, s_pix_addr, s_pix_data}, 64'd0);
    endtask

    initial begin
        int strobes;
        //           xo            yo            xs            ys            lat rnd hld mid
        vecs[0] = '{32'hF800_0000, 32'hFC00_0000, 32'h0200_0000, 32'h0200_0000, 3, 0, 0, 0,
                    32'hF800_0000, 32'hFC00_0000, 32'hFE00_0000, 32'hFE00_0000};
        vecs[1] = '{32'h0, 32'h0, 32'h1, 32'h10, 1, 1, 0, 0,
                    32'h0, 32'h0, 32'h3, 32'h10};
        vecs[2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1, 32'h1, 6, 1, 1, 0,
                    32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0002, 32'h8000_0000};
        vecs[3] = '{32'h10, 32'h20, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 2, 1, 0, 1,
                    32'h10, 32'h20, 32'h0D, 32'h10};

        // Reset held with random inputs.
        rst = 1'b0;
        repeat (6) begin
            tick();
            s_start  = 1'($urandom_range(0, 1));
            s_xo     = $urandom();
            s_yo     = $urandom();
            s_full_r = 1'($urandom_range(0, 1));
            s_full_i = 1'($urandom_range(0, 1));
        end
        chk_all_zero("rst");
        s_start  = 1'b0;
        s_full_r = 1'b0;
        s_full_i = 1'b0;
        tick();
        rst = 1'b1;
        strobes = 0;
        repeat (10) begin
            tick();
            if (s_wr || s_wi || s_rd || s_pix_we || s_busy || s_done) strobes++;
        end
        chk("idle_no_strobes", strobes, 0);

        for (int i = 0; i < 4; i++) run_frame(i);

        // Reset mid-frame, then restart from scratch.
        start_frame(0);
        wait_issues(3);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        pq.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        run_frame(0);

        // Credit limit: the big instance never sees a result.
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        repeat (200) tick();
        chk("credit_issues", b_iss, 16);
        chk("credit_busy", {63'd0, b_busy}, 64'd1);
        chk("credit_no_read", {63'd0, b_rd_seen}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Frame-level sequencer for the fractal `Pipe` datapath. It walks a MAX_X × MAX_Y pixel raster and generates fixed-point (real, imag) coordinates for each pixel. It feeds those coordinates into the Pipe's input FIFOs under full-flag and credit control, drains iteration counts from the Pipe's output FIFO, and emits one framebuffer write per pixel in raster order. It sits between the host/start logic and the Pipe, and replaces free-running stimulus with exact, flow-controlled issue.

## Interface
- BIT_WIDTH, 32, width of coordinates and result data
- MAX_X, 64, pixels per line
- MAX_Y, 48, lines per frame
- FLOAT_PRECISION, 26, fraction bits of coordinate format (two's complement); informational, arithmetic is plain integer add
- DEPTH, 16, maximum pixels outstanding inside the Pipe (credit limit)
- ADDR_W, $clog2(MAX_X*MAX_Y), framebuffer address width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- x_origin, y_origin  in  BIT_WIDTH  coordinate of pixel (0,0); latched on accepted start
- x_step, y_step  in  BIT_WIDTH  per-pixel / per-line increment; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last pixel written
- w_cntrl_real, w_cntrl_imag  out  1  Pipe write strobes (always driven identically)
- data_in_real, data_in_imag  out  BIT_WIDTH  coordinate to Pipe
- full_real, full_imag  in  1  Pipe input FIFO full flags
- r_cntrl  out  1  Pipe output FIFO read strobe
- data_out  in  BIT_WIDTH  Pipe result; valid the cycle after r_cntrl
- empty  in  1  Pipe output FIFO empty
- pix_we  out  1  framebuffer write strobe
- pix_addr  out  ADDR_W  framebuffer address = y*MAX_X + x
- pix_data  out  BIT_WIDTH  iteration count

## Operation
- All outputs are registered. Reset (rst=0, any time incl. mid-frame) forces: state IDLE, every output 0, all counters 0, and outstanding=0. Pipe contents are not flushed by this block.
- FSM states:
  - IDLE: on start=1, latch origin/step, set cur_x=x_origin, cur_y=y_origin, and clear issue/result counters. Go to RUN.
  - RUN: issue and drain.
  - DRAIN: all pixels issued; drain only.
  - DONE: pulse done, drop busy, and return to IDLE.
- Issue (RUN only): when full_real=0, full_imag=0, and outstanding<DEPTH, assert both w_cntrl for one cycle with cur_x/cur_y.
  - Advance x: cur_x += x_step.
  - At x index MAX_X-1: cur_x = x_origin, cur_y += y_step.
  - Adds wrap modulo 2^BIT_WIDTH.
  - After issue of pixel MAX_X*MAX_Y-1, go to DRAIN.
- Drain (RUN and DRAIN): when empty=0, outstanding>0, and no read is in flight, pulse r_cntrl. Capture data_out on the following cycle.
  - On capture: pix_we=1, pix_data=data_out, pix_addr=result counter; then increment the result counter.
  - At most one read per two cycles.
- outstanding: +1 on issue, −1 on capture; simultaneous issue and capture leaves it unchanged. Never exceeds DEPTH.
- Results are assumed in issue order (Pipe is FIFO-ordered). The address is therefore a sequential counter 0..MAX_X*MAX_Y−1.
- Leave DRAIN for DONE when the result counter reaches MAX_X*MAX_Y (after the last pix_we).
- start while busy is ignored.

## Timing
- start high at edge k: busy=1 after edge k. The first issue may be decided at edge k+1, so w_cntrl is visible in cycle k+1..k+2.
- Issue throughput: one pixel per cycle while unblocked.
- Flag reaction: full/empty sampled at the deciding edge.
  - Credit limit DEPTH guarantees no overflow even with a one-cycle-stale full.
- Read latency: r_cntrl at edge j → data_out captured at edge j+1 → pix_we visible in the cycle after edge j+1.
- done: one cycle, asserted the cycle after the final pix_we. busy falls together with done.
- No write/read strobes are asserted outside RUN/DRAIN.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0 and busy=0. Release, then idle 10 cycles → no strobes.
- Small frame (MAX_X=4, MAX_Y=2, FLOAT_PRECISION=26), origin (0xF8000000, 0xFC000000) i.e. (−2.0, −1.0), steps 0x02000000 (0.5). Model Pipe returns a fixed latency.
  - Required issue sequence: real −2.0, −1.5, −1.0, −0.5, then −2.0…; imag −1.0 ×4 then −0.5 ×4.
  - Exactly 8 pix_we at addr 0..7 with data in order, one done pulse, busy low afterwards.
- Backpressure: hold full_real=1 for 20 cycles mid-frame → zero w_cntrl during the hold. Resume on release with no pixel skipped or duplicated.
- Credit: model Pipe never produces results (empty=1) on a 64×48 frame → exactly 16 issues, then the block stalls with busy=1 and r_cntrl=0.
- Read discipline: empty toggling randomly → r_cntrl never asserted when empty=1, and never on consecutive cycles. pix_data equals the model's values in order.
- Control corner cases:
  - start pulsed mid-frame → ignored (total issues = 8).
  - rst=0 mid-frame → outputs 0 immediately.
  - Restart → first pix_addr=0 and first issue is x_origin.
